// File: rtl/dag.sv
// Data address generator: four I/M/L/B register sets, modify/circular-wrap
// datapath, registered data-memory address and combinational ureg readback.

module dag_set #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   wr_en,    // one-hot by ureg type: [0] I, [1] M, [2] L, [3] B
  input  logic [W-1:0] wr_val,
  input  logic         upd_en,
  input  logic [W-1:0] upd_val,
  output logic [W-1:0] i_q,
  output logic [W-1:0] m_q,
  output logic [W-1:0] l_q,
  output logic [W-1:0] b_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q <= '0;
      m_q <= '0;
      l_q <= '0;
      b_q <= '0;
    end else begin
      // An explicit ureg write to I overrides a same-edge post-modify update.
      if (wr_en[0])    i_q <= wr_val;
      else if (upd_en) i_q <= upd_val;
      if (wr_en[1]) m_q <= wr_val;
      if (wr_en[2]) l_q <= wr_val;
      if (wr_en[3]) b_q <= wr_val;
    end
  end

endmodule

module dag #(
  parameter int DMA_SIZE = 16,
  parameter int DMD_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dg_en,
  input  logic [1:0]          ps_dg_isel,
  input  logic [1:0]          ps_dg_msel,
  input  logic                ps_dg_pre,
  input  logic                ps_dg_imm_en,
  input  logic [DMA_SIZE-1:0] ps_dg_imm,
  input  logic                ps_dg_wrt_en,
  input  logic [3:0]          ps_dg_rd_add,
  input  logic [3:0]          ps_dg_wrt_add,
  input  logic [DMD_SIZE-1:0] bc_dg_dt,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

  logic [3:0][DMA_SIZE-1:0] i_r, m_r, l_r, b_r;
  logic [3:0][3:0]          wsel;
  logic [3:0]               upd;
  logic [DMA_SIZE-1:0]      wr_val;
  logic [DMA_SIZE-1:0]      cur_i, cur_l, cur_b, mod, sum, nxt;
  logic [DMA_SIZE:0]        top;
  logic [DMA_SIZE-1:0]      rd_val;

  assign wr_val = DMA_SIZE'(bc_dg_dt);

  for (genvar k = 0; k < 4; k++) begin : g_set
    assign wsel[k] = (ps_dg_wrt_en && ps_dg_wrt_add[1:0] == 2'(k))
                   ? (4'b0001 << ps_dg_wrt_add[3:2]) : 4'b0000;
    assign upd[k]  = ps_dg_en && !ps_dg_pre && ps_dg_isel == 2'(k);

    dag_set #(.W(DMA_SIZE)) u_set (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wsel[k]),
      .wr_val  (wr_val),
      .upd_en  (upd[k]),
      .upd_val (nxt),
      .i_q     (i_r[k]),
      .m_q     (m_r[k]),
      .l_q     (l_r[k]),
      .b_q     (b_r[k])
    );
  end

  // Shared modify/wrap datapath; reads pre-edge register values so same-cycle
  // ureg writes to M/L/B only take effect on the following request.
  always_comb begin
    cur_i = i_r[ps_dg_isel];
    cur_l = l_r[ps_dg_isel];
    cur_b = b_r[ps_dg_isel];
    mod   = ps_dg_imm_en ? ps_dg_imm : m_r[ps_dg_msel];
    sum   = cur_i + mod;
    top   = {1'b0, cur_b} + {1'b0, cur_l};
    nxt   = sum;
    if (cur_l != '0) begin
      if ({1'b0, sum} >= top) nxt = sum - cur_l;
      else if (sum < cur_b)   nxt = sum + cur_l;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        dg_dm_add <= '0;
    else if (ps_dg_en) dg_dm_add <= ps_dg_pre ? nxt : cur_i;
  end

  always_comb begin
    rd_val = '0;
    case (ps_dg_rd_add[3:2])
      2'b00:   rd_val = i_r[ps_dg_rd_add[1:0]];
      2'b01:   rd_val = m_r[ps_dg_rd_add[1:0]];
      2'b10:   rd_val = l_r[ps_dg_rd_add[1:0]];
      default: rd_val = b_r[ps_dg_rd_add[1:0]];
    endcase
  end

  assign dg_bc_dt = DMD_SIZE'(rd_val);

endmodule

// File: tb/tb_dag.sv
// Scoreboard bench for dag: stimulus pushes expected addresses, a monitor pops
// and compares each cycle; a flat 16-entry register model supplies expectations.

module tb_dag;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_dg_en, ps_dg_pre, ps_dg_imm_en, ps_dg_wrt_en;
  logic [1:0]  ps_dg_isel, ps_dg_msel;
  logic [15:0] ps_dg_imm, bc_dg_dt, dg_dm_add, dg_bc_dt;
  logic [3:0]  ps_dg_rd_add, ps_dg_wrt_add;

  int vecs = 0;
  int errs = 0;
  logic [15:0] mdl [16];     // 0-3 I, 4-7 M, 8-11 L, 12-15 B
  logic [15:0] expq [$];
  logic [15:0] last_exp;

  dag #(.DMA_SIZE(16), .DMD_SIZE(16)) dut (
    .clk(clk), .reset(reset), .ps_dg_en(ps_dg_en), .ps_dg_isel(ps_dg_isel),
    .ps_dg_msel(ps_dg_msel), .ps_dg_pre(ps_dg_pre), .ps_dg_imm_en(ps_dg_imm_en),
    .ps_dg_imm(ps_dg_imm), .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_rd_add(ps_dg_rd_add),
    .ps_dg_wrt_add(ps_dg_wrt_add), .bc_dg_dt(bc_dg_dt), .dg_dm_add(dg_dm_add),
    .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: every active edge outside reset, dg_dm_add must equal the
  // address queued for a request on that edge, or hold its previous value.
  initial begin
    logic en_s, rs_s;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      en_s = ps_dg_en;
      rs_s = reset;
      #1;
      if (rs_s && reset) begin
        if (en_s) begin
          if (expq.size() == 0) begin
            vecs++; errs++;
            $display("FAIL addr_q: request with empty queue, dm_add %h", dg_dm_add);
          end else begin
            e = expq.pop_front();
            last_exp = e;
          end
        end
        chk("dm_add", dg_dm_add, last_exp);
      end
    end
  end

  // One cycle: drive, check readback, predict, clock, update model.
  task automatic step(input logic en, input logic [1:0] isel, input logic [1:0] msel,
                      input logic pre, input logic imm_en, input logic [15:0] imm,
                      input logic wen, input logic [3:0] wadd, input logic [15:0] wd,
                      input logic [3:0] radd);
    int iv, md, lv, bv, s;
    ps_dg_en = en; ps_dg_isel = isel; ps_dg_msel = msel; ps_dg_pre = pre;
    ps_dg_imm_en = imm_en; ps_dg_imm = imm; ps_dg_wrt_en = wen;
    ps_dg_wrt_add = wadd; bc_dg_dt = wd; ps_dg_rd_add = radd;
    #1;
    chk("readback", dg_bc_dt, mdl[radd]);
    iv = int'(mdl[isel]);
    md = imm_en ? int'(imm) : int'(mdl[4 + int'(msel)]);
    lv = int'(mdl[8 + int'(isel)]);
    bv = int'(mdl[12 + int'(isel)]);
    s  = (iv + md) % 65536;
    if (lv != 0) begin
      if (s >= bv + lv)  s = s - lv;
      else if (s < bv)   s = (s + lv) % 65536;
    end
    if (en) expq.push_back(pre ? 16'(s) : 16'(iv));
    @(posedge clk);
    if (en && !pre) mdl[isel] = 16'(s);
    if (wen) mdl[wadd] = wd;
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b1, a, v, a);
  endtask

  task automatic idle(input logic [3:0] radd);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0, radd);
  endtask

  initial begin
    logic [15:0] circ [4];
    logic [3:0]  wa;
    circ[0] = 16'h0102; circ[1] = 16'h0103; circ[2] = 16'h0100; circ[3] = 16'h0101;
    for (int r = 0; r < 16; r++) mdl[r] = 16'h0;
    last_exp = 16'h0;
    reset = 1'b0;
    ps_dg_en = 0; ps_dg_isel = 0; ps_dg_msel = 0; ps_dg_pre = 0; ps_dg_imm_en = 0;
    ps_dg_imm = 0; ps_dg_wrt_en = 0; ps_dg_wrt_add = 0; bc_dg_dt = 0; ps_dg_rd_add = 0;
    #12;
    chk("reset_add", dg_dm_add, 16'h0);
    chk("reset_rd", dg_bc_dt, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Linear post-modify
    wr(4'd0, 16'h0010); wr(4'd4, 16'h0002); wr(4'd8, 16'h0000);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0);
      chk("lin_add", dg_dm_add, 16'(16'h0010 + 2 * n));
    end
    idle(4'd0);
    chk("lin_i0", dg_bc_dt, 16'h0016);

    // Circular wrap upward
    wr(4'd13, 16'h0100); wr(4'd9, 16'h0004); wr(4'd1, 16'h0102); wr(4'd5, 16'h0001);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd1);
      chk("circ_add", dg_dm_add, circ[n]);
    end

    // Negative immediate wraps below base
    wr(4'd14, 16'h0200); wr(4'd10, 16'h0008); wr(4'd2, 16'h0201);
    step(1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 4'd0, 16'h0, 4'd2);
    chk("neg_add", dg_dm_add, 16'h0201);
    idle(4'd2);
    chk("neg_i2", dg_bc_dt, 16'h0206);

    // Pre-modify leaves I untouched
    wr(4'd3, 16'h0040); wr(4'd7, 16'h0008); wr(4'd11, 16'h0000);
    step(1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3);
    chk("pre_add", dg_dm_add, 16'h0048);
    idle(4'd3);
    chk("pre_i3", dg_bc_dt, 16'h0040);

    // Ureg write beats post-modify on the same I register
    step(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b1, 4'd0, 16'h1234, 4'd0);
    chk("col_add", dg_dm_add, 16'h0016);
    idle(4'd0);
    chk("col_i0", dg_bc_dt, 16'h1234);

    // Randomized traffic, L kept small so wraps occur often
    for (int n = 0; n < 400; n++) begin
      wa = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0), wa,
           (wa[3:2] == 2'b10) ? 16'($urandom_range(0, 16)) : 16'($urandom),
           4'($urandom));
    end

    // Reset asserted mid-cycle with a request and a write pending
    ps_dg_en = 1'b1; ps_dg_isel = 2'd1; ps_dg_wrt_en = 1'b1;
    ps_dg_wrt_add = 4'd5; bc_dg_dt = 16'hBEEF;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_add", dg_dm_add, 16'h0);
    ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
    for (int r = 0; r < 16; r++) begin
      ps_dg_rd_add = 4'(r);
      #1;
      chk("rst_mid_rd", dg_bc_dt, 16'h0);
    end
    for (int r = 0; r < 16; r++) mdl[r] = 16'h0;
    expq.delete();
    last_exp = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    wr(4'd0, 16'h0055); wr(4'd4, 16'h0003);
    step(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0);
    chk("post_rst_add", dg_dm_add, 16'h0055);
    for (int n = 0; n < 20; n++)
      step(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
           1'b0, 4'd0, 16'h0, 4'($urandom));
    idle(4'd0);
    idle(4'd0);

    vecs++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d expected addresses never observed, want 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dag.md
DAG -- requirements
Module: dag

Interface
REQ-001 Parameter DMA_SIZE, default 16, data-memory address width.
REQ-002 Parameter DMD_SIZE, default 16, data-memory/ureg data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 ps_dg_en  in  1  address-generation request this cycle.
REQ-006 ps_dg_isel  in  2  index set select (I/B/L register set 0-3).
REQ-007 ps_dg_msel  in  2  modify register select (M0-M3).
REQ-008 ps_dg_pre  in  1  1 = pre-modify (no I update), 0 = post-modify (I updated).
REQ-009 ps_dg_imm_en  in  1  1 = use ps_dg_imm instead of M register.
REQ-010 ps_dg_imm  in  DMA_SIZE  immediate modifier, two's complement.
REQ-011 ps_dg_wrt_en  in  1  ureg write strobe.
REQ-012 ps_dg_rd_add, ps_dg_wrt_add  in  4 each  ureg address: [3:2] type (00 I, 01 M, 10 L, 11 B), [1:0] index.
REQ-013 bc_dg_dt  in  DMD_SIZE  ureg write data.
REQ-014 dg_dm_add  out  DMA_SIZE  registered data-memory address.
REQ-015 dg_bc_dt  out  DMD_SIZE  combinational ureg read data at ps_dg_rd_add.

Function
REQ-016 Block SHALL hold 16 registers I0-3, M0-3, L0-3, B0-3, each DMA_SIZE wide.
REQ-017 Modifier mod SHALL be ps_dg_imm when ps_dg_imm_en=1, else M[ps_dg_msel].
REQ-018 Sum s SHALL be I[isel]+mod, modulo 2^DMA_SIZE.
REQ-019 Circular wrap: if L[isel]=0, next=s; else if s >= B+L (unsigned, DMA_SIZE+1 bits), next=s-L; else if s < B, next=s+L; else next=s.
REQ-020 On ps_dg_en=1 with ps_dg_pre=0: dg_dm_add <= I[isel]; I[isel] <= next, same edge.
REQ-021 On ps_dg_en=1 with ps_dg_pre=1: dg_dm_add <= next; I[isel] unchanged.
REQ-022 Latency: address SHALL appear on dg_dm_add exactly one cycle after request, aligned with the sequencer's ps_dm_cslt for that access.
REQ-023 With ps_dg_en=0, dg_dm_add and all I registers SHALL hold.
REQ-024 ps_dg_wrt_en=1 SHALL write bc_dg_dt (zero-extended/truncated to DMA_SIZE) into addressed register at the edge.
REQ-025 Ureg write and post-modify to the same I register in one cycle: ureg write wins.
REQ-026 Ureg write to an M/L/B register used by a same-cycle request: request uses the old value; new value visible next cycle.
REQ-027 dg_bc_dt SHALL reflect current register contents (no write-through bypass), zero-extended/truncated to DMD_SIZE.
REQ-028 Back-to-back requests every cycle SHALL be supported with no stall.

Reset
REQ-029 reset low SHALL clear all 16 registers and dg_dm_add to 0 asynchronously.
REQ-030 A request or ureg write in progress at reset assertion SHALL be discarded; first edge after reset deassertion operates normally.

Verification
REQ-031 Linear post-modify: I0=0x0010, M0=0x0002, L0=0; 3 requests -> dg_dm_add 0x0010, 0x0012, 0x0014; I0=0x0016.
REQ-032 Circular wrap: B1=0x0100, L1=4, I1=0x0102, M1=1; 4 post-modify requests -> 0x0102, 0x0103, 0x0100, 0x0101.
REQ-033 Negative wrap: B2=0x0200, L2=8, I2=0x0201, imm=0xFFFD; post-modify -> dg_dm_add 0x0201, I2=0x0206.
REQ-034 Pre-modify: I3=0x0040, M3=0x0008, L3=0, pre=1 -> dg_dm_add 0x0048, I3 remains 0x0040.
REQ-035 Collision: post-modify on I0 and ureg write I0=0x1234 same cycle -> I0=0x1234, dg_dm_add = old I0.
REQ-036 Reset mid-stream: reset low during requests -> dg_dm_add=0, all registers 0 before next edge; readback via dg_bc_dt = 0.
